// File: rtl/writeback_commit_unit_l4.sv
// writeback_commit_unit_l4: per-pipe writeback completion plus in-order reorder-buffer commit
module writeback_commit_unit_l4 #(
    parameter int p_num_pipes      = 2,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6,
    parameter int p_commit_width   = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [p_num_pipes-1:0]                      ex_val,
    output logic [p_num_pipes-1:0]                      ex_rdy,
    input  logic [p_num_pipes*32-1:0]                   ex_pc,
    input  logic [p_num_pipes*p_seq_num_bits-1:0]       ex_seq_num,
    input  logic [p_num_pipes*5-1:0]                    ex_waddr,
    input  logic [p_num_pipes*32-1:0]                   ex_wdata,
    input  logic [p_num_pipes-1:0]                      ex_wen,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0]     ex_preg,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0]     ex_ppreg,
    output logic [p_num_pipes-1:0]                      complete_val,
    output logic [p_num_pipes*p_seq_num_bits-1:0]       complete_seq_num,
    output logic [p_num_pipes*5-1:0]                    complete_waddr,
    output logic [p_num_pipes*32-1:0]                   complete_wdata,
    output logic [p_num_pipes-1:0]                      complete_wen,
    output logic [p_num_pipes*p_phys_addr_bits-1:0]     complete_preg,
    output logic [p_commit_width-1:0]                   commit_val,
    output logic [p_commit_width*32-1:0]                commit_pc,
    output logic [p_commit_width*p_seq_num_bits-1:0]    commit_seq_num,
    output logic [p_commit_width*5-1:0]                 commit_waddr,
    output logic [p_commit_width*32-1:0]                commit_wdata,
    output logic [p_commit_width-1:0]                   commit_wen,
    output logic [p_commit_width*p_phys_addr_bits-1:0]  commit_ppreg
);
    localparam int P = p_num_pipes;
    localparam int S = p_seq_num_bits;
    localparam int A = p_phys_addr_bits;
    localparam int W = p_commit_width;
    localparam int D = 1 << S;

    logic [P-1:0]    in_val;
    logic [P*32-1:0] in_pc;
    logic [P*32-1:0] in_wdata;
    logic [P*S-1:0]  in_seq;
    logic [P*5-1:0]  in_waddr;
    logic [P-1:0]    in_wen;
    logic [P*A-1:0]  in_ppreg;

    logic [D-1:0]    rob_val;
    logic [D-1:0]    rob_wen;
    logic [31:0]     rob_pc [D];
    logic [31:0]     rob_wdata [D];
    logic [4:0]      rob_waddr [D];
    logic [A-1:0]    rob_ppreg [D];

    logic [S-1:0]    head;
    logic [S-1:0]    commit_cnt;
    logic [S-1:0]    cidx [W];
    logic            run;

    assign ex_rdy           = {P{rst}};
    assign complete_val     = ex_val & ex_rdy;
    assign complete_seq_num = ex_seq_num;
    assign complete_waddr   = ex_waddr;
    assign complete_wdata   = ex_wdata;
    assign complete_preg    = ex_preg;

    for (genvar i = 0; i < P; i++) begin : g_complete
        assign complete_wen[i] = ex_wen[i] & |ex_waddr[5*i +: 5];
    end

    for (genvar k = 0; k < W; k++) begin : g_commit
        assign cidx[k]                  = head + S'(k);
        assign commit_pc[32*k +: 32]    = rob_pc[cidx[k]];
        assign commit_seq_num[S*k +: S] = cidx[k];
        assign commit_waddr[5*k +: 5]   = rob_waddr[cidx[k]];
        assign commit_wdata[32*k +: 32] = rob_wdata[cidx[k]];
        assign commit_wen[k]            = rob_wen[cidx[k]];
        assign commit_ppreg[A*k +: A]   = rob_ppreg[cidx[k]];
    end

    // a lane commits only if every older slot from head up to it is valid
    always_comb begin
        run        = rst;
        commit_cnt = '0;
        commit_val = '0;
        for (int k = 0; k < W; k++) begin
            run           = run & rob_val[cidx[k]];
            commit_val[k] = run;
            commit_cnt    = commit_cnt + S'(run);
        end
    end

    always_ff @(posedge clk) begin
        in_pc    <= ex_pc;
        in_wdata <= ex_wdata;
        in_seq   <= ex_seq_num;
        in_waddr <= ex_waddr;
        in_wen   <= ex_wen;
        in_ppreg <= ex_ppreg;
        if (!rst) begin
            head    <= '0;
            rob_val <= '0;
            in_val  <= '0;
        end else begin
            in_val <= ex_val;
            head   <= head + commit_cnt;
            for (int k = 0; k < W; k++)
                if (commit_val[k]) rob_val[cidx[k]] <= 1'b0;
            for (int i = 0; i < P; i++) begin
                if (in_val[i]) begin
                    rob_val[in_seq[S*i +: S]]   <= 1'b1;
                    rob_pc[in_seq[S*i +: S]]    <= in_pc[32*i +: 32];
                    rob_wdata[in_seq[S*i +: S]] <= in_wdata[32*i +: 32];
                    rob_waddr[in_seq[S*i +: S]] <= in_waddr[5*i +: 5];
                    rob_wen[in_seq[S*i +: S]]   <= in_wen[i] & |in_waddr[5*i +: 5];
                    rob_ppreg[in_seq[S*i +: S]] <= in_ppreg[A*i +: A];
                end
            end
        end
    end
endmodule

// File: tb/tb_writeback_commit_unit_l4.sv
// tb_writeback_commit_unit_l4: directed scenarios plus randomized run against a reorder-window model
module tb_writeback_commit_unit_l4;
    localparam int P = 2;
    localparam int S = 2;
    localparam int A = 6;
    localparam int W = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [P-1:0]    ex_val = '0;
    logic [P-1:0]    ex_rdy;
    logic [P*32-1:0] ex_pc = '0;
    logic [P*S-1:0]  ex_seq_num = '0;
    logic [P*5-1:0]  ex_waddr = '0;
    logic [P*32-1:0] ex_wdata = '0;
    logic [P-1:0]    ex_wen = '0;
    logic [P*A-1:0]  ex_preg = '0;
    logic [P*A-1:0]  ex_ppreg = '0;
    logic [P-1:0]    complete_val;
    logic [P*S-1:0]  complete_seq_num;
    logic [P*5-1:0]  complete_waddr;
    logic [P*32-1:0] complete_wdata;
    logic [P-1:0]    complete_wen;
    logic [P*A-1:0]  complete_preg;
    logic [W-1:0]    commit_val;
    logic [W*32-1:0] commit_pc;
    logic [W*S-1:0]  commit_seq_num;
    logic [W*5-1:0]  commit_waddr;
    logic [W*32-1:0] commit_wdata;
    logic [W-1:0]    commit_wen;
    logic [W*A-1:0]  commit_ppreg;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]  pc;
        logic [S-1:0] seq;
        logic [4:0]   waddr;
        logic [31:0]  wdata;
        logic         wen;
        logic [A-1:0] preg;
        logic [A-1:0] ppreg;
    } msg_t;

    writeback_commit_unit_l4 #(
        .p_num_pipes(P), .p_seq_num_bits(S), .p_phys_addr_bits(A), .p_commit_width(W)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_val(ex_val), .ex_rdy(ex_rdy), .ex_pc(ex_pc), .ex_seq_num(ex_seq_num),
        .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_wen(ex_wen), .ex_preg(ex_preg),
        .ex_ppreg(ex_ppreg),
        .complete_val(complete_val), .complete_seq_num(complete_seq_num),
        .complete_waddr(complete_waddr), .complete_wdata(complete_wdata),
        .complete_wen(complete_wen), .complete_preg(complete_preg),
        .commit_val(commit_val), .commit_pc(commit_pc), .commit_seq_num(commit_seq_num),
        .commit_waddr(commit_waddr), .commit_wdata(commit_wdata), .commit_wen(commit_wen),
        .commit_ppreg(commit_ppreg)
    );

    always #5 clk = ~clk;

    function automatic msg_t mk(input int seq, input logic [4:0] waddr, input logic [31:0] wdata, input logic wen);
        msg_t m;
        m.pc    = 32'h400 + 32'(seq) * 4;
        m.seq   = S'(seq);
        m.waddr = waddr;
        m.wdata = wdata;
        m.wen   = wen;
        m.preg  = A'(seq + 8);
        m.ppreg = A'(seq + 16);
        return m;
    endfunction

    task automatic set_lane(input int i, input msg_t m);
        ex_val[i]             = 1'b1;
        ex_pc[32*i +: 32]     = m.pc;
        ex_seq_num[S*i +: S]  = m.seq;
        ex_waddr[5*i +: 5]    = m.waddr;
        ex_wdata[32*i +: 32]  = m.wdata;
        ex_wen[i]             = m.wen;
        ex_preg[A*i +: A]     = m.preg;
        ex_ppreg[A*i +: A]    = m.ppreg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ex_val = '0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        ex_val = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_lane(0, mk(0, 5'd3, 32'h1, 1'b1));
        set_lane(1, mk(1, 5'd4, 32'h2, 1'b1));
        repeat (2) @(posedge clk);
        sample();
        checks++;
        if ({ex_rdy, complete_val, commit_val} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs rdy/cval/commit got=%b exp=000000", {ex_rdy, complete_val, commit_val});
        end
        do_reset();
        sample();
        checks++;
        if (ex_rdy !== 2'b11 || commit_val !== 2'b00) begin
            failures++;
            $display("FAIL reset_release rdy=%b commit_val=%b exp rdy=11 commit_val=00", ex_rdy, commit_val);
        end
    endtask

    task automatic test_single();
        do_reset();
        tick();
        set_lane(0, mk(0, 5'd3, 32'hDEAD, 1'b1));
        sample();
        checks++;
        if ({complete_val, complete_seq_num[S-1:0], complete_waddr[4:0], complete_wdata[31:0], complete_wen[0], complete_preg[A-1:0]}
            !== {2'b01, 2'd0, 5'd3, 32'hDEAD, 1'b1, 6'd8}) begin
            failures++;
            $display("FAIL single_complete val=%b seq=%0d wdata=%h wen=%b exp val=01 seq=0 wdata=dead wen=1",
                     complete_val, complete_seq_num[S-1:0], complete_wdata[31:0], complete_wen[0]);
        end
        for (int c = 1; c <= 2; c++) begin
            if (c == 2) tick();
            checks++;
            if (commit_val !== 2'b00) begin
                failures++;
                $display("FAIL single_early_commit cycle=%0d got=%b exp=00", c, commit_val);
            end
        end
        tick();
        sample();
        checks++;
        if ({commit_val, commit_seq_num[S-1:0], commit_waddr[4:0], commit_wdata[31:0], commit_wen[0], commit_pc[31:0], commit_ppreg[A-1:0]}
            !== {2'b01, 2'd0, 5'd3, 32'hDEAD, 1'b1, 32'h400, 6'd16}) begin
            failures++;
            $display("FAIL single_commit val=%b seq=%0d wdata=%h pc=%h exp val=01 seq=0 wdata=dead pc=400",
                     commit_val, commit_seq_num[S-1:0], commit_wdata[31:0], commit_pc[31:0]);
        end
        tick();
        sample();
        checks++;
        if (commit_val !== 2'b00) begin
            failures++;
            $display("FAIL single_after got=%b exp=00", commit_val);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        tick();
        set_lane(0, mk(1, 5'd7, 32'h0111, 1'b1));
        sample();
        for (int c = 2; c <= 4; c++) begin
            tick();
            if (c == 3) set_lane(0, mk(0, 5'd6, 32'h0100, 1'b1));
            sample();
            checks++;
            if (commit_val !== 2'b00) begin
                failures++;
                $display("FAIL ooo_hold cycle=%0d got=%b exp=00", c, commit_val);
            end
        end
        tick();
        sample();
        checks++;
        if ({commit_val, commit_seq_num, commit_wdata} !== {2'b11, 2'd1, 2'd0, 32'h0111, 32'h0100}) begin
            failures++;
            $display("FAIL ooo_commit val=%b seq=%h wdata=%h exp val=11 seq=4 wdata=0000011100000100",
                     commit_val, commit_seq_num, commit_wdata);
        end
    endtask

    task automatic test_x0();
        do_reset();
        tick();
        set_lane(0, mk(0, 5'd0, 32'h1111, 1'b1));
        set_lane(1, mk(1, 5'd5, 32'h2222, 1'b1));
        sample();
        checks++;
        if ({complete_val, complete_wen} !== 4'b1110) begin
            failures++;
            $display("FAIL x0_complete val=%b wen=%b exp val=11 wen=10", complete_val, complete_wen);
        end
        tick();
        tick();
        sample();
        checks++;
        if ({commit_val, commit_wen, commit_waddr} !== {2'b11, 2'b10, 5'd5, 5'd0}) begin
            failures++;
            $display("FAIL x0_commit val=%b wen=%b waddr=%h exp val=11 wen=10 waddr=a0", commit_val, commit_wen, commit_waddr);
        end
    endtask

    task automatic test_width();
        do_reset();
        tick();
        set_lane(0, mk(0, 5'd1, 32'hA0, 1'b1));
        set_lane(1, mk(1, 5'd2, 32'hA1, 1'b1));
        tick();
        set_lane(0, mk(2, 5'd3, 32'hA2, 1'b1));
        tick();
        sample();
        checks++;
        if ({commit_val, commit_seq_num} !== {2'b11, 2'd1, 2'd0}) begin
            failures++;
            $display("FAIL width_c3 val=%b seq=%h exp val=11 seq=4", commit_val, commit_seq_num);
        end
        tick();
        sample();
        checks++;
        if ({commit_val, commit_seq_num[S-1:0], commit_wdata[31:0]} !== {2'b01, 2'd2, 32'hA2}) begin
            failures++;
            $display("FAIL width_c4 val=%b seq=%0d wdata=%h exp val=01 seq=2 wdata=a2",
                     commit_val, commit_seq_num[S-1:0], commit_wdata[31:0]);
        end
        tick();
        set_lane(1, mk(3, 5'd4, 32'hA3, 1'b1));
        sample();
        checks++;
        if (commit_val !== 2'b00) begin
            failures++;
            $display("FAIL width_c5 got=%b exp=00", commit_val);
        end
        tick();
        tick();
        sample();
        checks++;
        if ({commit_val, commit_seq_num[S-1:0], commit_wdata[31:0]} !== {2'b01, 2'd3, 32'hA3}) begin
            failures++;
            $display("FAIL width_head3 val=%b seq=%0d wdata=%h exp val=01 seq=3 wdata=a3",
                     commit_val, commit_seq_num[S-1:0], commit_wdata[31:0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        set_lane(0, mk(0, 5'd1, 32'hA0, 1'b1));
        set_lane(1, mk(1, 5'd2, 32'hA1, 1'b1));
        tick();
        set_lane(0, mk(2, 5'd3, 32'hA2, 1'b1));
        tick();
        set_lane(0, mk(3, 5'd4, 32'hA3, 1'b1));
        set_lane(1, mk(0, 5'd9, 32'hB0, 1'b1));
        sample();
        checks++;
        if ({commit_val, commit_seq_num} !== {2'b11, 2'd1, 2'd0}) begin
            failures++;
            $display("FAIL wrap_c3 val=%b seq=%h exp val=11 seq=4", commit_val, commit_seq_num);
        end
        tick();
        set_lane(0, mk(1, 5'd10, 32'hB1, 1'b1));
        sample();
        checks++;
        if ({commit_val, commit_seq_num[S-1:0]} !== {2'b01, 2'd2}) begin
            failures++;
            $display("FAIL wrap_c4 val=%b seq=%0d exp val=01 seq=2", commit_val, commit_seq_num[S-1:0]);
        end
        tick();
        sample();
        checks++;
        if ({commit_val, commit_seq_num, commit_wdata} !== {2'b11, 2'd0, 2'd3, 32'hB0, 32'hA3}) begin
            failures++;
            $display("FAIL wrap_c5 val=%b seq=%h wdata=%h exp val=11 seq=3 wdata=000000b0000000a3",
                     commit_val, commit_seq_num, commit_wdata);
        end
        tick();
        sample();
        checks++;
        if ({commit_val, commit_seq_num[S-1:0], commit_wdata[31:0]} !== {2'b01, 2'd1, 32'hB1}) begin
            failures++;
            $display("FAIL wrap_c6 val=%b seq=%0d wdata=%h exp val=01 seq=1 wdata=b1",
                     commit_val, commit_seq_num[S-1:0], commit_wdata[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        set_lane(0, mk(1, 5'd3, 32'hC1, 1'b1));
        tick();
        set_lane(1, mk(2, 5'd3, 32'hC2, 1'b1));
        tick();
        rst = 1'b0;
        set_lane(0, mk(0, 5'd3, 32'hCC, 1'b1));
        set_lane(1, mk(3, 5'd3, 32'hCD, 1'b1));
        sample();
        checks++;
        if ({ex_rdy, complete_val, commit_val} !== 6'b0) begin
            failures++;
            $display("FAIL midreset_outputs rdy/cval/commit got=%b exp=000000", {ex_rdy, complete_val, commit_val});
        end
        tick();
        rst = 1'b1;
        set_lane(0, mk(0, 5'd3, 32'hC0, 1'b1));
        for (int c = 4; c <= 8; c++) begin
            if (c > 4) tick();
            sample();
            checks++;
            if (c == 6) begin
                if ({commit_val, commit_seq_num[S-1:0], commit_wdata[31:0]} !== {2'b01, 2'd0, 32'hC0}) begin
                    failures++;
                    $display("FAIL midreset_commit val=%b seq=%0d wdata=%h exp val=01 seq=0 wdata=c0",
                             commit_val, commit_seq_num[S-1:0], commit_wdata[31:0]);
                end
            end else if (commit_val !== 2'b00) begin
                failures++;
                $display("FAIL midreset_quiet cycle=%0d got=%b exp=00", c, commit_val);
            end
        end
    endtask

    task automatic test_random();
        logic   m_val [D];
        msg_t   m_pay [D];
        msg_t   q [$];
        msg_t   cur [P];
        int     m_head;
        int     n;
        int     s;
        bit     free;
        logic [D-1:0] used;
        logic [P-1:0] exp_wen;
        msg_t   m;
        do_reset();
        m_head = 0;
        for (int j = 0; j < D; j++) m_val[j] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            rst  = ($urandom_range(0, 59) != 0);
            used = '0;
            for (int i = 0; i < P; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    s = (m_head + $urandom_range(0, D - 1)) % D;
                    free = !m_val[s] && !used[s];
                    foreach (q[j]) if (q[j].seq == S'(s)) free = 0;
                    if (free) begin
                        m.pc    = $urandom;
                        m.seq   = S'(s);
                        m.waddr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                        m.wdata = $urandom;
                        m.wen   = 1'($urandom_range(0, 1));
                        m.preg  = A'($urandom);
                        m.ppreg = A'($urandom);
                        set_lane(i, m);
                        cur[i]  = m;
                        used[s] = 1'b1;
                    end
                end
            end
            sample();
            for (int i = 0; i < P; i++) exp_wen[i] = ex_wen[i] && (ex_waddr[5*i +: 5] != 5'd0);
            checks++;
            if ({ex_rdy, complete_val} !== {{P{rst}}, ex_val & {P{rst}}} || ((complete_wen ^ exp_wen) & complete_val) != '0) begin
                failures++;
                $display("FAIL rand_complete cycle=%0d rdy=%b val=%b wen=%b exp rdy=%b val=%b wen=%b",
                         cyc, ex_rdy, complete_val, complete_wen, {P{rst}}, ex_val & {P{rst}}, exp_wen);
            end
            n = 0;
            if (rst) while (n < W && m_val[(m_head + n) % D]) n++;
            checks++;
            if (commit_val !== W'((1 << n) - 1)) begin
                failures++;
                $display("FAIL rand_commit_val cycle=%0d got=%b exp=%b", cyc, commit_val, W'((1 << n) - 1));
            end
            for (int k = 0; k < n; k++) begin
                m = m_pay[(m_head + k) % D];
                checks++;
                if ({commit_pc[32*k +: 32], commit_seq_num[S*k +: S], commit_waddr[5*k +: 5], commit_wdata[32*k +: 32],
                     commit_wen[k], commit_ppreg[A*k +: A]}
                    !== {m.pc, S'((m_head + k) % D), m.waddr, m.wdata, m.wen && (m.waddr != 5'd0), m.ppreg}) begin
                    failures++;
                    $display("FAIL rand_commit_lane%0d cycle=%0d seq=%0d wdata=%h wen=%b exp seq=%0d wdata=%h wen=%b",
                             k, cyc, commit_seq_num[S*k +: S], commit_wdata[32*k +: 32], commit_wen[k],
                             (m_head + k) % D, m.wdata, m.wen && (m.waddr != 5'd0));
                end
            end
            if (!rst) begin
                for (int j = 0; j < D; j++) m_val[j] = 1'b0;
                q.delete();
                m_head = 0;
            end else begin
                for (int k = 0; k < n; k++) m_val[(m_head + k) % D] = 1'b0;
                m_head = (m_head + n) % D;
                foreach (q[j]) begin
                    m_val[q[j].seq] = 1'b1;
                    m_pay[q[j].seq] = q[j];
                end
                q.delete();
                for (int i = 0; i < P; i++) if (ex_val[i]) q.push_back(cur[i]);
            end
        end
        tick();
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_out_of_order();
        test_x0();
        test_width();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
